call_stack_unit: RTL and testbench

- Sequences call/return requests from decode and drives the link register's write port (lr_wr_en, lr_in).
- Consumes the committed LR value (lr_out) to form return targets.
- Spills the previous LR into a small circular hardware stack on call and refills it from the stack on return, so nested calls need no software save.
- Sits between decode/branch logic and the link register.

---
 rtl/d16_cs_pkg.sv | 16 +
 rtl/cs_lifo.sv | 48 ++++
 rtl/call_stack_unit.sv | 140 ++++++++++++++
 tb/tb_call_stack_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/d16_cs_pkg.sv
// Shared definitions for the call stack unit: request op encodings, FSM state type
// and call-length increments.
package d16_cs_pkg;

  localparam logic OP_CALL = 1'b0;
  localparam logic OP_RET  = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  localparam int INSN_BYTES      = 2;
  localparam int LONG_INSN_BYTES = 4;

endpackage

// File: rtl/cs_lifo.sv
// Circular LIFO of link-register values. A push onto a full stack overwrites the oldest
// entry. The top of the stack can be read combinationally.
module cs_lifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_push_data,
  output logic [AW-1:0] o_top_data,
  output logic [CW-1:0] o_count
);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Storage has no reset; the valid count alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + 1'b1;
      if (!w_full) r_count <= r_count + 1'b1;
    end else if (i_pop && !w_empty) begin
      r_ptr   <= r_ptr - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_top_data = r_mem[r_ptr - 1'b1];
  assign o_count    = r_count;

endmodule

// File: rtl/call_stack_unit.sv
// Call/return sequencer. It drives the LR write port and spills/refills the LR through a
// hardware stack. Define CALL_STACK_STATS_EN to add the call_count, ret_count and
// max_depth outputs.
module call_stack_unit
  import d16_cs_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [AW-1:0] req_pc,
  input  logic          req_len,
  input  logic [AW-1:0] req_target,
  input  logic [AW-1:0] lr_out,
  output logic          lr_wr_en,
  output logic [AW-1:0] lr_in,
  output logic          br_valid,
  output logic [AW-1:0] br_target,
  output logic [CW-1:0] depth_cnt,
  output logic          overflow,
`ifdef CALL_STACK_STATS_EN
  output logic [AW-1:0] call_count,
  output logic [AW-1:0] ret_count,
  output logic [CW-1:0] max_depth,
`endif
  output logic          underflow
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_is_call;
  logic          w_push;
  logic          w_pop;
  logic          w_stack_full;
  logic          w_stack_empty;
  logic [AW-1:0] w_top;
  logic [CW-1:0] w_count;
  logic [AW-1:0] w_ret_addr;

  logic          r_br_valid;
  logic [AW-1:0] r_br_target;
  logic          r_lr_wr_en;
  logic [AW-1:0] r_lr_in;
  logic          r_overflow;
  logic          r_underflow;

  assign w_accept      = req_valid && req_ready;
  assign w_is_call     = (req_op == OP_CALL);
  assign w_stack_full  = (w_count == CW'(DEPTH));
  assign w_stack_empty = (w_count == '0);
  assign w_push        = w_accept && w_is_call;
  assign w_pop         = w_accept && !w_is_call && !w_stack_empty;
  assign w_ret_addr    = req_pc + (req_len ? AW'(LONG_INSN_BYTES) : AW'(INSN_BYTES));

  cs_lifo #(.DEPTH(DEPTH), .AW(AW)) u_lifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_data(lr_out),
    .o_top_data (w_top),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // COMMIT blocks a new request until the LR write has landed.
  always_comb begin
    req_ready = (r_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_valid  <= 1'b0;
      r_br_target <= '0;
      r_lr_wr_en  <= 1'b0;
      r_lr_in     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_br_valid <= w_accept;
      r_lr_wr_en <= w_push || w_pop;
      if (w_accept) begin
        r_br_target <= w_is_call ? req_target : lr_out;
        r_lr_in     <= w_is_call ? w_ret_addr : w_top;
      end
      if (w_push && w_stack_full) r_overflow <= 1'b1;
      if (w_accept && !w_is_call && w_stack_empty) r_underflow <= 1'b1;
    end
  end

  assign br_valid  = r_br_valid;
  assign br_target = r_br_target;
  assign lr_wr_en  = r_lr_wr_en;
  assign lr_in     = r_lr_in;
  assign depth_cnt = w_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef CALL_STACK_STATS_EN
  logic [AW-1:0] r_call_count;
  logic [AW-1:0] r_ret_count;
  logic [CW-1:0] r_max_depth;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_call_count <= '0;
      r_ret_count  <= '0;
      r_max_depth  <= '0;
    end else begin
      if (w_push) r_call_count <= r_call_count + 1'b1;
      if (w_accept && !w_is_call) r_ret_count <= r_ret_count + 1'b1;
      if (w_count > r_max_depth) r_max_depth <= w_count;
    end
  end

  assign call_count = r_call_count;
  assign ret_count  = r_ret_count;
  assign max_depth  = r_max_depth;
`endif

endmodule

// File: tb/tb_call_stack_unit.sv
// Self-checking bench for call_stack_unit: directed scenarios and then random call/return
// traffic. Every result is compared against a queue-based model of the stack.
module tb_call_stack_unit;
  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [AW-1:0] req_pc;
  logic          req_len;
  logic [AW-1:0] req_target;
  logic [AW-1:0] lr_out;
  logic          lr_wr_en;
  logic [AW-1:0] lr_in;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic [CW-1:0] depth_cnt;
  logic          overflow;
  logic          underflow;
`ifdef CALL_STACK_STATS_EN
  logic [AW-1:0] call_count;
  logic [AW-1:0] ret_count;
  logic [CW-1:0] max_depth;
`endif

  call_stack_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_pc    (req_pc),
    .req_len   (req_len),
    .req_target(req_target),
    .lr_out    (lr_out),
    .lr_wr_en  (lr_wr_en),
    .lr_in     (lr_in),
    .br_valid  (br_valid),
    .br_target (br_target),
    .depth_cnt (depth_cnt),
    .overflow  (overflow),
`ifdef CALL_STACK_STATS_EN
    .call_count(call_count),
    .ret_count (ret_count),
    .max_depth (max_depth),
`endif
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the live stack entries, oldest first.
  logic [AW-1:0] m_stack[$];
  bit            m_ovf;
  bit            m_unf;
  int            m_calls;
  int            m_rets;
  int            m_max;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_ovf   = 0;
    m_unf   = 0;
    m_calls = 0;
    m_rets  = 0;
    m_max   = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_brv"},   32'(br_valid), 0);
    check_eq({tag, "_lrwe"},  32'(lr_wr_en), 0);
    check_eq({tag, "_rdy"},   32'(req_ready), 1);
    check_eq({tag, "_depth"}, 32'(depth_cnt), 32'(m_stack.size()));
    check_eq({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    check_eq({tag, "_unf"},   32'(underflow), 32'(m_unf));
`ifdef CALL_STACK_STATS_EN
    check_eq({tag, "_calls"}, 32'(call_count), 32'(m_calls % 65536));
    check_eq({tag, "_rets"},  32'(ret_count), 32'(m_rets % 65536));
    check_eq({tag, "_maxd"},  32'(max_depth), 32'(m_max));
`endif
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_eq("rst_brt", 32'(br_target), 0);
    check_eq("rst_lrin", 32'(lr_in), 0);
    check_idle_outputs("rst");
  endtask

  // Issue one request from IDLE (#1 after an edge). Returns in IDLE, #1 after an edge.
  task automatic do_req(input bit op, input logic [AW-1:0] pc, input bit len,
                        input logic [AW-1:0] tgt, input logic [AW-1:0] lr);
    logic [AW-1:0] exp_br;
    logic [AW-1:0] exp_lrin;
    bit            exp_wr;
    exp_lrin = '0;
    if (op == 1'b0) begin
      exp_br   = tgt;
      exp_wr   = 1;
      exp_lrin = pc + (len ? 16'd4 : 16'd2);
      m_stack.push_back(lr);
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1;
      end
      m_calls++;
    end else begin
      exp_br = lr;
      m_rets++;
      if (m_stack.size() > 0) begin
        exp_wr   = 1;
        exp_lrin = m_stack.pop_back();
      end else begin
        exp_wr = 0;
        m_unf  = 1;
      end
    end
    if (m_stack.size() > m_max) m_max = m_stack.size();

    check_eq("req_rdy", 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_op     = op;
    req_pc     = pc;
    req_len    = len;
    req_target = tgt;
    lr_out     = lr;
    @(posedge clk);
    #1;
    // An offer during COMMIT must be ignored.
    req_valid  = 1'($urandom_range(0, 1));
    req_op     = 1'($urandom);
    req_pc     = 16'($urandom);
    req_target = 16'($urandom);
    lr_out     = 16'($urandom);
    check_eq("cm_brv",   32'(br_valid), 1);
    check_eq("cm_brt",   32'(br_target), 32'(exp_br));
    check_eq("cm_lrwe",  32'(lr_wr_en), 32'(exp_wr));
    if (exp_wr) check_eq("cm_lrin", 32'(lr_in), 32'(exp_lrin));
    check_eq("cm_rdy",   32'(req_ready), 0);
    check_eq("cm_depth", 32'(depth_cnt), 32'(m_stack.size()));
    check_eq("cm_ovf",   32'(overflow), 32'(m_ovf));
    check_eq("cm_unf",   32'(underflow), 32'(m_unf));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_idle_outputs("post");
  endtask

  initial begin
    req_valid  = 1'b0;
    req_op     = 1'b0;
    req_pc     = '0;
    req_len    = 1'b0;
    req_target = '0;
    lr_out     = '0;
    do_reset();

    do_req(1'b0, 16'h0100, 1'b0, 16'h0400, 16'h1234);
    do_req(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0102);
    do_req(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0050);
    do_req(1'b0, 16'h0200, 1'b1, 16'h0600, 16'h0777);
    check_eq("unf_sticky", 32'(underflow), 1);

    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++)
      do_req(1'b0, 16'($urandom), 1'($urandom), 16'($urandom), 16'(i));
    check_eq("ovf_full", 32'(depth_cnt), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b1, 16'h0, 1'b0, 16'h0, 16'($urandom));
      check_eq("pop_order", 32'(lr_in), 32'(DEPTH + 1 - i));
    end
    do_req(1'b1, 16'h0, 1'b0, 16'h0, 16'h0033);
    check_eq("unf_after_drain", 32'(underflow), 1);

    do_reset();
    do_req(1'b0, 16'hFFFE, 1'b1, 16'h1000, 16'h0042);
    do_req(1'b0, 16'h0010, 1'b0, 16'h2000, 16'h0043);
    do_req(1'b0, 16'h0020, 1'b0, 16'h3000, 16'h0044);
    do_req(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0022);
    do_req(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0012);
`ifdef CALL_STACK_STATS_EN
    check_eq("st_calls", 32'(call_count), 3);
    check_eq("st_rets",  32'(ret_count), 2);
    check_eq("st_maxd",  32'(max_depth), 3);
`endif

    // Reset while in COMMIT.
    req_valid = 1'b1; req_op = 1'b0; req_pc = 16'hFFFE; req_len = 1'b1;
    req_target = 16'h0800; lr_out = 16'h0099;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rc_brv", 32'(br_valid), 1);
    check_eq("rc_lrin", 32'(lr_in), 32'h0002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_idle_outputs("rc");

    // Reset wins over an accept on the same edge.
    rst = 1'b1; req_valid = 1'b1; req_op = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;
    check_idle_outputs("rwin");
    @(posedge clk);
    #1;
    check_idle_outputs("rwin2");

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      do_req(1'($urandom_range(0, 99) < 45), 16'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
